// File: rtl/countdown_bar.sv
// Countdown bar overlay: a timer that shrinks a horizontal bar one pixel every
// MS_PER_PIXEL millisecond ticks, drawn into a 1-cycle-latency VGA pixel stream.
module countdown_bar #(
  parameter int          BAR_X        = 0,
  parameter int          BAR_Y        = 575,
  parameter int          BAR_WIDTH    = 800,
  parameter int          BAR_HEIGHT   = 25,
  parameter int          MS_PER_PIXEL = 40,
  parameter int          WARN_PIXELS  = 100,
  parameter logic [11:0] BAR_COLOR    = 12'h0F0,
  parameter logic [11:0] BAR_BG_COLOR = 12'h444,
  parameter logic [11:0] WARN_COLOR   = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en_i,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        add_time_i,
  input  logic [9:0]  add_pixels_i,
  input  logic        one_ms_tick_i,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [11:0] rgb_i,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb_o,
  output logic [9:0]  remaining_o,
  output logic        warning_o,
  output logic        elapsed_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_EXPIRED = 3'd4
  } state_e;

  localparam logic [10:0] FULL     = 11'(BAR_WIDTH);
  localparam logic [10:0] WARN_LIM = 11'(WARN_PIXELS);
  localparam logic [9:0]  MS_LAST  = 10'(MS_PER_PIXEL - 1);
  localparam logic [11:0] X_LO     = 12'(BAR_X);
  localparam logic [11:0] X_HI     = 12'(BAR_X + BAR_WIDTH);
  localparam logic [11:0] Y_LO     = 12'(BAR_Y);
  localparam logic [11:0] Y_HI     = 12'(BAR_Y + BAR_HEIGHT);

  state_e      state_q, state_d;
  logic [9:0]  rem_q, rem_d;
  logic [9:0]  ms_q, ms_d;
  logic        warning_q, warning_d;
  logic        elapsed_q, elapsed_d;
  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q;
  logic [11:0] rgb_q, rgb_d;

  logic        tick_run, wrap, dec;
  logic [10:0] sum, added;
  logic [9:0]  rem_run;
  logic [11:0] h_off;
  logic        in_bar;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ms_d     = ms_q;
    tick_run = (state_q == S_RUNNING) && !pause_i && one_ms_tick_i;
    wrap     = tick_run && (ms_q == MS_LAST);
    // dec is guarded so remaining never wraps below zero
    dec      = wrap && (rem_q != 10'd0);
    sum      = {1'b0, rem_q} + {1'b0, add_pixels_i} - {10'd0, dec};
    added    = (sum > FULL) ? FULL : sum;
    rem_run  = add_time_i ? added[9:0] : (rem_q - {9'd0, dec});

    if (!module_en_i) begin
      state_d = S_IDLE;
      rem_d   = 10'd0;
      ms_d    = 10'd0;
    end else if (state_q == S_IDLE) begin
      state_d = S_READY;
    end else if (start_i) begin
      state_d = S_RUNNING;
      rem_d   = FULL[9:0];
      ms_d    = 10'd0;
    end else if (state_q == S_RUNNING || state_q == S_PAUSED) begin
      rem_d = rem_run;
      if (tick_run) ms_d = wrap ? 10'd0 : ms_q + 10'd1;
      // Expiry is seen one cycle after remaining reached zero, unless a bonus lands
      if (state_q == S_RUNNING && rem_q == 10'd0 && rem_run == 10'd0) state_d = S_EXPIRED;
      else if (state_q == S_RUNNING && pause_i)                      state_d = S_PAUSED;
      else if (state_q == S_PAUSED && !pause_i)                      state_d = S_RUNNING;
    end

    warning_d = (state_d == S_RUNNING || state_d == S_PAUSED) && ({1'b0, rem_d} <= WARN_LIM);
    elapsed_d = (state_d == S_EXPIRED);
  end

  always_comb begin
    h_off  = {1'b0, hcount_i} - X_LO;
    in_bar = ({1'b0, hcount_i} >= X_LO) && ({1'b0, hcount_i} < X_HI) &&
             ({1'b0, vcount_i} >= Y_LO) && ({1'b0, vcount_i} < Y_HI);
    rgb_d  = rgb_i;
    if (in_bar) begin
      case (state_q)
        S_READY:             rgb_d = BAR_COLOR;
        S_RUNNING, S_PAUSED: rgb_d = (h_off < {2'b00, rem_q}) ?
                                     (warning_q ? WARN_COLOR : BAR_COLOR) : BAR_BG_COLOR;
        S_EXPIRED:           rgb_d = BAR_BG_COLOR;
        default:             rgb_d = rgb_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= 10'd0;
      ms_q      <= 10'd0;
      warning_q <= 1'b0;
      elapsed_q <= 1'b0;
      hcount_q  <= 11'd0;
      vcount_q  <= 11'd0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      rgb_q     <= 12'd0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ms_q      <= ms_d;
      warning_q <= warning_d;
      elapsed_q <= elapsed_d;
      hcount_q  <= hcount_i;
      vcount_q  <= vcount_i;
      hsync_q   <= hsync_i;
      vsync_q   <= vsync_i;
      rgb_q     <= rgb_d;
    end
  end

  assign hcount_o    = hcount_q;
  assign vcount_o    = vcount_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign rgb_o       = rgb_q;
  assign remaining_o = rem_q;
  assign warning_o   = warning_q;
  assign elapsed_o   = elapsed_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_countdown_bar.sv
// Bench for countdown_bar: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural timer/pixel model.
module tb_countdown_bar;

  localparam int W    = 8;
  localparam int MS   = 2;
  localparam int WARN = 2;
  localparam int BX   = 0;
  localparam int BY   = 0;
  localparam int BH   = 2;
  localparam logic [11:0] C_BAR  = 12'h0F0;
  localparam logic [11:0] C_BG   = 12'h444;
  localparam logic [11:0] C_WARN = 12'hF00;

  // model modes
  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en_i = 1'b0, start_i = 1'b0, pause_i = 1'b0, add_time_i = 1'b0;
  logic [9:0]  add_pixels_i = 10'd0;
  logic        one_ms_tick_i = 1'b0;
  logic [10:0] hcount_i = 11'd0, vcount_i = 11'd0;
  logic        hsync_i = 1'b0, vsync_i = 1'b0;
  logic [11:0] rgb_i = 12'd0;
  logic [10:0] hcount_o, vcount_o;
  logic        hsync_o, vsync_o;
  logic [11:0] rgb_o;
  logic [9:0]  remaining_o;
  logic        warning_o, elapsed_o;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;
  bit rand_pix = 1'b1;

  countdown_bar #(
    .BAR_X(BX), .BAR_Y(BY), .BAR_WIDTH(W), .BAR_HEIGHT(BH),
    .MS_PER_PIXEL(MS), .WARN_PIXELS(WARN),
    .BAR_COLOR(C_BAR), .BAR_BG_COLOR(C_BG), .WARN_COLOR(C_WARN)
  ) dut (
    .clk(clk), .rst(rst),
    .module_en_i(module_en_i), .start_i(start_i), .pause_i(pause_i),
    .add_time_i(add_time_i), .add_pixels_i(add_pixels_i), .one_ms_tick_i(one_ms_tick_i),
    .hcount_i(hcount_i), .vcount_i(vcount_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .rgb_i(rgb_i),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .rgb_o(rgb_o), .remaining_o(remaining_o), .warning_o(warning_o),
    .elapsed_o(elapsed_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock, then drop single-cycle pulses and refresh pixel inputs
  task automatic step();
    @(posedge clk);
    #2;
    start_i       = 1'b0;
    add_time_i    = 1'b0;
    one_ms_tick_i = 1'b0;
    if (rand_pix) begin
      hcount_i = 11'($urandom_range(0, 13));
      vcount_i = 11'($urandom_range(0, 3));
      hsync_i  = 1'($urandom_range(0, 1));
      vsync_i  = 1'($urandom_range(0, 1));
      rgb_i    = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic tick_step();
    one_ms_tick_i = 1'b1;
    step();
    step();
  endtask

  // behavioural model + scoreboard
  int  m_mode = M_IDLE, m_rem = 0, m_ms = 0;
  bit  m_warn = 1'b0, m_elapsed = 1'b0, m_valid = 1'b0;
  logic [35:0] exp_q[$];

  always @(posedge clk) begin
    int h, v, px, dec, nrem;
    bit in_bar;
    if (rst) begin
      m_valid = 1'b1;
      m_mode = M_IDLE; m_rem = 0; m_ms = 0; m_warn = 0; m_elapsed = 0;
      exp_q.delete();
    end else begin
      h = int'(hcount_i);
      v = int'(vcount_i);
      in_bar = (h >= BX) && (h < BX + W) && (v >= BY) && (v < BY + BH);
      px = int'(rgb_i);
      if (in_bar) begin
        if (m_mode == M_READY) px = int'(C_BAR);
        else if (m_mode == M_EXP) px = int'(C_BG);
        else if (m_mode == M_RUN || m_mode == M_PAUSE)
          px = (h - BX < m_rem) ? ((m_rem <= WARN) ? int'(C_WARN) : int'(C_BAR)) : int'(C_BG);
      end
      exp_q.push_back({hcount_i, vcount_i, hsync_i, vsync_i, 12'(px)});

      if (!module_en_i) begin
        m_mode = M_IDLE; m_rem = 0; m_ms = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_READY;
      end else if (start_i) begin
        m_mode = M_RUN; m_rem = W; m_ms = 0;
      end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
        dec = 0;
        if (m_mode == M_RUN && !pause_i && one_ms_tick_i) begin
          m_ms = m_ms + 1;
          if (m_ms == MS) begin
            m_ms = 0;
            if (m_rem > 0) dec = 1;
          end
        end
        nrem = m_rem - dec;
        if (add_time_i) begin
          nrem = m_rem + int'(add_pixels_i) - dec;
          if (nrem > W) nrem = W;
        end
        if (m_mode == M_RUN && m_rem == 0 && nrem == 0) m_mode = M_EXP;
        else if (m_mode == M_RUN && pause_i) m_mode = M_PAUSE;
        else if (m_mode == M_PAUSE && !pause_i) m_mode = M_RUN;
        m_rem = nrem;
      end
      m_warn    = (m_mode == M_RUN || m_mode == M_PAUSE) && (m_rem <= WARN);
      m_elapsed = (m_mode == M_EXP);
    end
  end

  // compare process: every cycle once reset has been seen
  always @(negedge clk) begin
    logic [35:0] e;
    if (m_valid) begin
      check("remaining", 36'(remaining_o), 36'(m_rem));
      check("warning", 36'(warning_o), 36'(m_warn));
      check("elapsed", 36'(elapsed_o), 36'(m_elapsed));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vga", {hcount_o, vcount_o, hsync_o, vsync_o, rgb_o}, e);
      end else begin
        check("vga_reset", {hcount_o, vcount_o, hsync_o, vsync_o, rgb_o}, 36'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(); step(); step();
    check("rst_remaining", 36'(remaining_o), 36'd0);
    check("rst_elapsed", 36'(elapsed_o), 36'd0);
    check("rst_warning", 36'(warning_o), 36'd0);
    check("rst_rgb", 36'(rgb_o), 36'd0);

    rst = 1'b0;
    module_en_i = 1'b1;
    step();
    start_i = 1'b1;
    step();
    check("start_full", 36'(remaining_o), 36'd8);
    check("start_no_warn", 36'(warning_o), 36'd0);

    for (int k = 1; k <= 16; k++) begin
      one_ms_tick_i = 1'b1;
      step();
      if (k == 2)  check("tick2_rem", 36'(remaining_o), 36'd7);
      if (k == 3)  check("tick3_rem", 36'(remaining_o), 36'd7);
      if (k == 12) check("tick12_warn", 36'(warning_o), 36'd1);
      if (k == 16) begin
        check("tick16_rem", 36'(remaining_o), 36'd0);
        check("tick16_not_elapsed", 36'(elapsed_o), 36'd0);
      end
      step();
    end
    check("expired_elapsed", 36'(elapsed_o), 36'd1);

    start_i = 1'b1;
    step();
    check("restart_rem", 36'(remaining_o), 36'd8);
    check("restart_elapsed", 36'(elapsed_o), 36'd0);

    for (int k = 0; k < 10; k++) tick_step();
    check("down_to_3", 36'(remaining_o), 36'd3);
    add_time_i = 1'b1; add_pixels_i = 10'd10;
    step();
    check("add_clamped", 36'(remaining_o), 36'd8);
    for (int k = 0; k < 10; k++) tick_step();
    tick_step();
    one_ms_tick_i = 1'b1; add_time_i = 1'b1; add_pixels_i = 10'd1;
    step();
    check("add_with_dec", 36'(remaining_o), 36'd3);

    tick_step();
    pause_i = 1'b1;
    step();
    for (int k = 0; k < 10; k++) tick_step();
    check("paused_hold", 36'(remaining_o), 36'd3);
    pause_i = 1'b0;
    step();
    tick_step();
    check("resume_held_ms", 36'(remaining_o), 36'd2);
    check("warn_at_2", 36'(warning_o), 36'd1);

    rand_pix = 1'b0;
    for (int h = 0; h < 10; h++) begin
      hcount_i = 11'(h); vcount_i = 11'd0; rgb_i = 12'h123;
      step();
      check("scan_hcount", 36'(hcount_o), 36'(h));
      check("scan_rgb", 36'(rgb_o), (h < 2) ? 36'(C_WARN) : (h < 8) ? 36'(C_BG) : 36'h123);
    end

    module_en_i = 1'b0;
    step();
    check("disable_warn", 36'(warning_o), 36'd0);
    check("disable_elapsed", 36'(elapsed_o), 36'd0);
    hcount_i = 11'd3; vcount_i = 11'd0; rgb_i = 12'hABC;
    step();
    check("idle_passthru", 36'(rgb_o), 36'hABC);
    module_en_i = 1'b1;
    step();
    step();
    check("ready_bar", 36'(rgb_o), 36'(C_BAR));

    start_i = 1'b1;
    step();
    tick_step(); tick_step(); tick_step();
    rst = 1'b1;
    step();
    check("abort_rem", 36'(remaining_o), 36'd0);
    check("abort_rgb", 36'(rgb_o), 36'd0);
    rst = 1'b0;
    step(); step();
    check("abort_no_elapsed", 36'(elapsed_o), 36'd0);

    rand_pix = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 599) == 0);
      module_en_i   = ($urandom_range(0, 59) != 0);
      start_i       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) pause_i = ~pause_i;
      add_time_i    = ($urandom_range(0, 14) == 0);
      add_pixels_i  = $urandom_range(0, 1) ? 10'($urandom_range(0, 5)) : 10'($urandom_range(0, 1023));
      one_ms_tick_i = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
